// File: rtl/dualmem_narrow_pkg.sv
// Shared types and helpers for the 64-bit to 16-bit narrowing stream buffer.
// Holds the FIFO entry layout, the serializer state encoding and the keep decode.
package dualmem_narrow_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 64;
  localparam int LANES  = 4;
  localparam int NL_W   = 3;

  typedef struct packed {
    logic              last;
    logic [NL_W-1:0]   nlanes;
    logic [WORD_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  // Only contiguous low-aligned lane masks are legal.
  function automatic logic keep_legal(input logic [LANES-1:0] keep);
    logic ok;
    case (keep)
      4'b0001, 4'b0011, 4'b0111, 4'b1111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Illegal masks fall back to a full word so no data is silently dropped.
  function automatic logic [NL_W-1:0] keep_to_nlanes(input logic [LANES-1:0] keep);
    logic [NL_W-1:0] n;
    case (keep)
      4'b0001: n = 3'd1;
      4'b0011: n = 3'd2;
      4'b0111: n = 3'd3;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/narrow_sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers and a combinational read port.
// Writes are refused when full, even if a read happens on the same edge.
module narrow_sync_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dualmem_narrow_stream.sv
// 64-bit to 16-bit narrowing stream buffer: word FIFO followed by a halfword
// serializer that emits lanes low-first and chains words without bubbles.
module dualmem_narrow_stream
  import dualmem_narrow_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LANES-1:0]  in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] out_data,
  output logic              out_last,
  output logic [LVL_W-1:0]  fill_level,
  output logic              keep_err
);

  entry_t               wr_entry;
  entry_t               head;
  logic [ENTRY_W-1:0]   wr_vec;
  logic [ENTRY_W-1:0]   rd_vec;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 wr_en;
  logic                 pop;
  logic                 shift;
  logic                 lane_final;

  ser_state_t           state;
  ser_state_t           state_nxt;

  logic [WORD_W-1:0]    word_p1;
  logic [1:0]           lane_p1;
  logic [NL_W-1:0]      nlanes_p1;
  logic                 last_p1;

  // Sink side: decode keep into a lane count and enqueue the word.
  assign in_ready = !fifo_full && !rst;
  assign wr_en    = in_valid && in_ready;

  always_comb begin
    wr_entry.last   = in_last;
    wr_entry.nlanes = keep_to_nlanes(in_keep);
    wr_entry.data   = in_data;
  end

  assign wr_vec = wr_entry;
  assign head   = entry_t'(rd_vec);

  narrow_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_vec),
    .rd_en   (pop),
    .rd_data (rd_vec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keep_err <= 1'b0;
    end else if (wr_en && !keep_legal(in_keep)) begin
      keep_err <= 1'b1;
    end
  end

  // Serializer stage: state register, next-state logic, output/control logic.
  assign lane_final = ({1'b0, lane_p1} == (nlanes_p1 - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!fifo_empty) state_nxt = S_SEND;
      S_SEND: if (out_ready && lane_final && fifo_empty) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    pop       = 1'b0;
    shift     = 1'b0;
    case (state)
      S_IDLE: begin
        pop = !fifo_empty;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = lane_final && last_p1;
        pop       = out_ready && lane_final && !fifo_empty;
        shift     = out_ready && !lane_final;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_p1   <= '0;
      lane_p1   <= '0;
      nlanes_p1 <= 3'd1;
      last_p1   <= 1'b0;
    end else if (pop) begin
      word_p1   <= head.data;
      lane_p1   <= '0;
      nlanes_p1 <= head.nlanes;
      last_p1   <= head.last;
    end else if (shift) begin
      word_p1   <= word_p1 >> HALF_W;
      lane_p1   <= lane_p1 + 2'd1;
    end
  end

  assign out_data = word_p1[HALF_W-1:0];

endmodule

// File: tb/tb_dualmem_narrow_stream.sv
// Directed bench for dualmem_narrow_stream with a halfword scoreboard and
// a negedge monitor that checks order, out_last and stall stability.
module tb_dualmem_narrow_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [3:0]  in_keep = 4'b1111;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic [3:0]  fill_level;
  logic        keep_err;

  int vectors = 0;
  int miscompares = 0;

  logic [16:0] sb[$];
  logic        hold = 1'b0;
  logic [15:0] hold_d = '0;
  logic        hold_l = 1'b0;

  always #5 clk = ~clk;

  dualmem_narrow_stream #(.DEPTH(8), .LVL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_keep    (in_keep),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fill_level (fill_level),
    .keep_err   (keep_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_lanes(input logic [3:0] k);
    case (k)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  task automatic send_word(input logic [63:0] d, input logic [3:0] k, input logic l);
    int n;
    int nl;
    logic [63:0] w;
    n  = 0;
    nl = model_lanes(k);
    w  = d;
    for (int i = 0; i < nl; i++) begin
      sb.push_back({(l && (i == nl - 1)), w[15:0]});
      w = w >> 16;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    assert (n < 200) else begin
      miscompares++;
      $error("FAIL accept_timeout: observed %0d cycles waited, expected < 200", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    chk({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_d));
        chk("hold_last", 64'(out_last), 64'(hold_l));
      end
      hold = 1'b0;
      if (out_valid && out_ready) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_halfword: observed %0h with empty scoreboard, expected none", out_data);
        end
        if (sb.size() != 0) begin
          logic [16:0] e;
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e[15:0]));
          chk("out_last", 64'(out_last), 64'(e[16]));
        end
      end else if (out_valid) begin
        hold   = 1'b1;
        hold_d = out_data;
        hold_l = out_last;
      end
    end
  end

  initial begin
    // 1: power-on reset, then reset asserted in the middle of a burst
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_keep_err", 64'(keep_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    send_word(64'h0D0D_0C0C_0B0B_0A0A, 4'b1111, 1'b0);
    send_word(64'h1D1D_1C1C_1B1B_1A1A, 4'b1111, 1'b1);
    send_word(64'h2D2D_2C2C_2B2B_2A2A, 4'b1111, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_fill", 64'(fill_level), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("midrst_idle", 64'(out_valid), 64'd0);

    // 2: single full word, latency and back-to-back lanes
    send_word(64'h4444_3333_2222_1111, 4'b1111, 1'b1);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_first", 64'(out_valid), 64'd1);
    chk("lat_first_data", 64'(out_data), 64'h1111);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("consec_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    chk("single_done", 64'(out_valid), 64'd0);
    drain("single", 20);

    // 3: two-lane word
    send_word(64'hFFFF_FFFF_BBBB_AAAA, 4'b0011, 1'b1);
    drain("keep0011", 20);
    chk("keep0011_err", 64'(keep_err), 64'd0);

    // 4: fill FIFO and serializer with the sink stalled, then drain with wrap
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [63:0] d;
      d = {16'(16'hA000 + i*4 + 3), 16'(16'hA000 + i*4 + 2),
           16'(16'hA000 + i*4 + 1), 16'(16'hA000 + i*4)};
      send_word(d, 4'b1111, (i % 3) == 2);
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_fill", 64'(fill_level), 64'd8);
    @(posedge clk); #1;
    chk("full_fill_hold", 64'(fill_level), 64'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 36; i++) begin
      chk("burst_no_gap", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    drain("burst", 10);
    chk("burst_fill", 64'(fill_level), 64'd0);

    // 5: toggling backpressure over mixed lane counts
    out_ready = 1'b0;
    send_word(64'h0000_0000_0000_5001, 4'b0001, 1'b1);
    send_word(64'h0000_5013_5012_5011, 4'b0111, 1'b0);
    send_word(64'h5024_5023_5022_5021, 4'b1111, 1'b1);
    send_word(64'h0000_0000_5032_5031, 4'b0011, 1'b0);
    for (int i = 0; i < 80 && (sb.size() != 0 || out_valid); i++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain("toggle", 10);

    // 6: illegal keep mask is sticky until reset
    send_word(64'h6004_6003_6002_6001, 4'b0101, 1'b1);
    drain("keep0101", 20);
    chk("keep0101_err", 64'(keep_err), 64'd1);
    send_word(64'h0000_0000_0000_7001, 4'b0001, 1'b1);
    drain("after_err", 20);
    chk("keep_err_sticky", 64'(keep_err), 64'd1);
    rst = 1'b1;
    #1 chk("keep_err_cleared", 64'(keep_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
